// File: rtl/mask_line_stats_pkg.sv
// Shared constants for the per-line mask statistics engine:
// CI command codes, status bit positions and entry field widths.
package mask_line_stats_pkg;

    localparam logic [3:0] CMD_READ_LINES = 4'd0;
    localparam logic [3:0] CMD_COUNT      = 4'd1;
    localparam logic [3:0] CMD_SUM        = 4'd2;
    localparam logic [3:0] CMD_STATUS     = 4'd3;
    localparam logic [3:0] CMD_HOLD       = 4'd4;
    localparam logic [3:0] CMD_CLEAR      = 4'd5;
    localparam logic [3:0] CMD_DROPPED    = 4'd6;

    localparam int STATUS_READY_BIT = 0;
    localparam int STATUS_HOLD_BIT  = 1;
    localparam int STATUS_OVF_BIT   = 2;

    function automatic int count_bits(input int x_bits);
        return x_bits + 1;
    endfunction

    function automatic int sum_bits(input int x_bits);
        return 2 * x_bits;
    endfunction

    function automatic int entry_bits(input int x_bits);
        return 3 * x_bits + 1;
    endfunction

endpackage

// File: rtl/line_stats_ram.sv
// Simple dual-port line-entry RAM, addressed {bank, line}; the registered
// read port provides the single-cycle CI read latency.
module line_stats_ram
    import mask_line_stats_pkg::*;
#(
    parameter int WIDTH     = entry_bits(11),
    parameter int ADDR_BITS = 10
) (
    input  logic                 clock,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mask_line_stats.sv
// Per-line mask pixel count and x-sum accumulator with double-buffered
// frame banks, hold mode and custom-instruction readout.
module mask_line_stats
    import mask_line_stats_pkg::*;
#(
    parameter logic [7:0] customInstructionId = 8'd0,
    parameter int         nrOfLanes           = 2,
    parameter int         xBits               = 11,
    parameter int         maxLines            = 512
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frameStart,
    input  logic                 lineEnd,
    input  logic                 pixelValid,
    input  logic [nrOfLanes-1:0] pixelMask,
    input  logic                 ciStart,
    input  logic                 ciCke,
    input  logic [7:0]           ciN,
    input  logic [31:0]          ciValueA,
    input  logic [31:0]          ciValueB,
    output logic [31:0]          ciResult,
    output logic                 ciDone,
    output logic                 frameReady
);

    localparam int COUNT_BITS = count_bits(xBits);
    localparam int SUM_BITS   = sum_bits(xBits);
    localparam int ENTRY_BITS = entry_bits(xBits);
    localparam int LINE_BITS  = $clog2(maxLines);
    localparam int IDX_BITS   = LINE_BITS + 1;

    logic [xBits-1:0]      x_reg;
    logic [COUNT_BITS-1:0] count_reg;
    logic [SUM_BITS-1:0]   sum_reg;
    logic [IDX_BITS-1:0]   line_idx;
    logic [IDX_BITS-1:0]   read_lines;
    logic                  rd_bank;
    logic                  hold;
    logic                  overflow;
    logic                  frame_ready_reg;
    logic [7:0]            dropped;

    logic [COUNT_BITS-1:0] beat_count;
    logic [SUM_BITS-1:0]   beat_sum;
    logic [COUNT_BITS-1:0] line_count;
    logic [SUM_BITS:0]     sum_wide;
    logic [SUM_BITS-1:0]   line_sum;
    logic                  line_full;
    logic                  wr_en;
    logic [IDX_BITS-1:0]   idx_after_end;
    logic                  swap;
    logic                  drop_frame;

    logic                  is_mine;
    logic [3:0]            ci_cmd;
    logic                  in_range;
    logic [31:0]           status;
    logic                  done_q;
    logic [3:0]            cmd_q;
    logic                  range_q;
    logic [31:0]           result_q;
    logic [ENTRY_BITS-1:0] rd_data;
    logic                  unused_bits;

    assign unused_bits = ^ciValueA[31:4];

    // Lane i of a beat sits at x_reg+i; computed wide so the last lanes never wrap.
    always_comb begin
        beat_count = '0;
        beat_sum   = '0;
        for (int i = 0; i < nrOfLanes; i++) begin
            if (pixelMask[i]) begin
                beat_count = beat_count + COUNT_BITS'(1);
                beat_sum   = beat_sum + SUM_BITS'(x_reg) + SUM_BITS'(i);
            end
        end
    end

    // The beat arriving with lineEnd is folded in before the line is written.
    assign line_count    = count_reg + (pixelValid ? beat_count : '0);
    assign sum_wide      = {1'b0, sum_reg} + {1'b0, (pixelValid ? beat_sum : '0)};
    assign line_sum      = sum_wide[SUM_BITS] ? '1 : sum_wide[SUM_BITS-1:0];
    assign line_full     = (line_idx == IDX_BITS'(maxLines));
    assign wr_en         = lineEnd && !line_full;
    assign idx_after_end = wr_en ? line_idx + IDX_BITS'(1) : line_idx;
    assign swap          = frameStart && !hold;
    assign drop_frame    = frameStart && hold;

    assign is_mine  = ciStart && ciCke && (ciN == customInstructionId);
    assign ci_cmd   = ciValueA[3:0];
    assign in_range = ciValueB < 32'(read_lines);

    always_comb begin
        status                   = '0;
        status[STATUS_READY_BIT] = frame_ready_reg;
        status[STATUS_HOLD_BIT]  = hold;
        status[STATUS_OVF_BIT]   = overflow;
    end

    line_stats_ram #(
        .WIDTH     (ENTRY_BITS),
        .ADDR_BITS (LINE_BITS + 1)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr ({~rd_bank, line_idx[LINE_BITS-1:0]}),
        .wr_data ({line_sum, line_count}),
        .rd_addr ({rd_bank, ciValueB[LINE_BITS-1:0]}),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_reg     <= '0;
            count_reg <= '0;
            sum_reg   <= '0;
            line_idx  <= '0;
        end else begin
            if (frameStart || lineEnd) begin
                x_reg     <= '0;
                count_reg <= '0;
                sum_reg   <= '0;
            end else if (pixelValid) begin
                x_reg     <= x_reg + xBits'(nrOfLanes);
                count_reg <= line_count;
                sum_reg   <= line_sum;
            end
            line_idx <= frameStart ? '0 : idx_after_end;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_bank         <= 1'b0;
            read_lines      <= '0;
            frame_ready_reg <= 1'b0;
            overflow        <= 1'b0;
            hold            <= 1'b0;
            dropped         <= '0;
        end else begin
            if (swap) begin
                rd_bank    <= ~rd_bank;
                read_lines <= idx_after_end;
            end
            if (swap) begin
                frame_ready_reg <= 1'b1;
            end else if (is_mine && ci_cmd == CMD_CLEAR) begin
                frame_ready_reg <= 1'b0;
            end
            if (lineEnd && line_full) begin
                overflow <= 1'b1;
            end else if (is_mine && ci_cmd == CMD_CLEAR) begin
                overflow <= 1'b0;
            end
            if (is_mine && ci_cmd == CMD_HOLD) begin
                hold <= ciValueB[0];
            end
            // A read clears the counter but still counts a frame dropped in the same cycle.
            if (is_mine && ci_cmd == CMD_DROPPED) begin
                dropped <= drop_frame ? 8'd1 : 8'd0;
            end else if (drop_frame && dropped != 8'hFF) begin
                dropped <= dropped + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_q   <= 1'b0;
            cmd_q    <= '0;
            range_q  <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= is_mine;
            if (is_mine) begin
                cmd_q   <= ci_cmd;
                range_q <= in_range;
                case (ci_cmd)
                    CMD_READ_LINES: result_q <= 32'(read_lines);
                    CMD_STATUS:     result_q <= status;
                    CMD_DROPPED:    result_q <= 32'(dropped);
                    default:        result_q <= '0;
                endcase
            end
        end
    end

    always_comb begin
        ciResult = '0;
        if (done_q) begin
            case (cmd_q)
                CMD_COUNT: ciResult = range_q ? 32'(rd_data[COUNT_BITS-1:0]) : '0;
                CMD_SUM:   ciResult = range_q ? 32'(rd_data[ENTRY_BITS-1:COUNT_BITS]) : '0;
                default:   ciResult = result_q;
            endcase
        end
    end

    assign ciDone     = done_q;
    assign frameReady = frame_ready_reg;

endmodule

// File: tb/tb_mask_line_stats.sv
// Scoreboard bench for mask_line_stats: CI issues queue their expected
// results, a negedge monitor checks ciDone timing and pops on every ciDone.
module tb_mask_line_stats;

    logic        clock = 1'b0;
    logic        reset;
    logic        frameStart, lineEnd, pixelValid;
    logic [1:0]  pixelMask;
    logic        ciStart, ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciValueA, ciValueB;
    logic [31:0] ciResult;
    logic        ciDone, frameReady;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        prev_mine = 1'b0;

    always #5 clock = ~clock;

    mask_line_stats #(
        .customInstructionId (8'd0),
        .nrOfLanes           (2),
        .xBits               (11),
        .maxLines            (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .frameStart (frameStart),
        .lineEnd    (lineEnd),
        .pixelValid (pixelValid),
        .pixelMask  (pixelMask),
        .ciStart    (ciStart),
        .ciCke      (ciCke),
        .ciN        (ciN),
        .ciValueA   (ciValueA),
        .ciValueB   (ciValueB),
        .ciResult   (ciResult),
        .ciDone     (ciDone),
        .frameReady (frameReady)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            exp_q.delete();
            name_q.delete();
            prev_mine = 1'b0;
        end else begin
            check("ci_done_timing", 32'(ciDone), 32'(prev_mine));
            if (ciDone) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=%0d required=none", ciResult);
                end else begin
                    check(name_q.pop_front(), ciResult, exp_q.pop_front());
                end
            end else begin
                check("ci_result_idle", ciResult, 32'd0);
            end
            prev_mine = ciStart && ciCke && (ciN == 8'd0);
        end
    end

    task automatic cyc(input logic pv, input logic [1:0] m, input logic le, input logic fs,
                       input logic cs, input logic [7:0] n, input logic [3:0] cmd,
                       input logic [31:0] b);
        @(posedge clock);
        #1;
        pixelValid = pv;
        pixelMask  = m;
        lineEnd    = le;
        frameStart = fs;
        ciStart    = cs;
        ciCke      = cs;
        ciN        = n;
        ciValueA   = {28'd0, cmd};
        ciValueB   = b;
    endtask

    task automatic idle();
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 32'd0);
    endtask
    task automatic beat(input logic [1:0] m);
        cyc(1'b1, m, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 32'd0);
    endtask
    task automatic beat_end(input logic [1:0] m);
        cyc(1'b1, m, 1'b1, 1'b0, 1'b0, 8'd0, 4'd0, 32'd0);
    endtask
    task automatic line_end();
        cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd0, 4'd0, 32'd0);
    endtask
    task automatic frame();
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0, 4'd0, 32'd0);
    endtask
    task automatic ci(input logic [3:0] cmd, input logic [31:0] b, input logic [31:0] e,
                      input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'd0, cmd, b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        frameStart = 1'b0; lineEnd = 1'b0; pixelValid = 1'b0; pixelMask = 2'b00;
        ciStart = 1'b0; ciCke = 1'b0; ciN = 8'd0; ciValueA = '0; ciValueB = '0;
        #22 reset = 1'b1;

        ci(4'd0, 0, 0, "rst_read_lines");
        ci(4'd3, 0, 0, "rst_status");
        ci(4'd1, 0, 0, "rst_count_l0");
        idle();

        // frame of three lines
        beat(2'b01); beat(2'b10); beat(2'b00); line_end();
        line_end();
        beat(2'b11); line_end();
        frame();
        ci(4'd0, 0, 3, "f1_read_lines");
        ci(4'd1, 0, 2, "f1_count_l0");
        ci(4'd1, 1, 0, "f1_count_l1");
        ci(4'd1, 2, 2, "f1_count_l2");
        ci(4'd2, 0, 3, "f1_sum_l0");
        ci(4'd2, 1, 0, "f1_sum_l1");
        ci(4'd2, 2, 1, "f1_sum_l2");
        ci(4'd3, 0, 1, "f1_status");
        ci(4'd1, 3, 0, "f1_count_oob");
        ci(4'd9, 0, 0, "unknown_cmd");
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'd5, 4'd0, 32'd0);
        idle();

        // beat together with lineEnd, then a partial line discarded by frameStart
        beat(2'b00); beat(2'b00); beat_end(2'b11);
        beat(2'b11);
        frame();
        ci(4'd0, 0, 1, "prec_read_lines");
        ci(4'd1, 0, 2, "prec_count");
        ci(4'd2, 0, 9, "prec_sum");
        ci(4'd5, 0, 0, "clear");
        ci(4'd3, 0, 0, "status_cleared");

        // hold: three dropped frames
        ci(4'd4, 1, 0, "hold_on");
        ci(4'd3, 0, 2, "status_hold");
        beat(2'b10); line_end();
        frame(); idle(); frame();
        beat(2'b11);
        frame();
        ci(4'd0, 0, 1, "hold_read_lines");
        ci(4'd1, 0, 2, "hold_count");
        ci(4'd2, 0, 9, "hold_sum");
        ci(4'd6, 0, 3, "dropped");
        ci(4'd6, 0, 0, "dropped_cleared");
        ci(4'd3, 0, 2, "status_hold2");
        ci(4'd4, 0, 0, "hold_off");
        beat(2'b01); beat(2'b01); line_end();
        frame();
        ci(4'd0, 0, 1, "swap_read_lines");
        ci(4'd2, 0, 2, "swap_sum");
        ci(4'd3, 0, 1, "swap_status");

        // lineEnd and frameStart together
        beat(2'b11);
        cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 8'd0, 4'd0, 32'd0);
        ci(4'd0, 0, 1, "sim_read_lines");
        ci(4'd1, 0, 2, "sim_count");
        ci(4'd2, 0, 1, "sim_sum");

        // overflow with four line entries
        repeat (6) line_end();
        frame();
        ci(4'd0, 0, 4, "ovf_read_lines");
        ci(4'd3, 0, 5, "ovf_status");
        ci(4'd5, 0, 0, "ovf_clear");
        ci(4'd3, 0, 0, "ovf_status_cleared");

        // clear in the same cycle as a swap: the swap keeps frameReady
        line_end(); line_end();
        exp_q.push_back(0);
        name_q.push_back("clear_with_swap");
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 8'd0, 4'd5, 32'd0);
        ci(4'd3, 0, 1, "swap_beats_clear");
        ci(4'd0, 0, 2, "pre_reset_lines");

        // async reset mid-line and mid-CI
        beat(2'b11);
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0, 32'd0);
        idle();
        check("pre_reset_done", 32'(ciDone), 32'd1);
        check("pre_reset_ready", 32'(frameReady), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("reset_done_drop", 32'(ciDone), 32'd0);
        check("reset_ready_drop", 32'(frameReady), 32'd0);
        check("reset_result_zero", ciResult, 32'd0);
        #20 reset = 1'b1;
        ci(4'd0, 0, 0, "post_reset_lines");
        ci(4'd3, 0, 0, "post_reset_status");
        idle();

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
        end
        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
